// File: rtl/mibench_drv_pkg.sv
// Shared types and defaults for the mibench call driver: FSM states and the
// (index, returndata) result entry carried through the result FIFO.
package mibench_drv_pkg;

    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_e;

    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] data;
    } result_t;

endpackage

// File: rtl/mibench_call_driver_if.sv
// Host command/result and component call/return signals of the call driver.
// master = the driver itself, slave = host plus component side.
interface mibench_call_driver_if
    import mibench_drv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_base;
    logic [CNT_W-1:0] cmd_count;

    logic             comp_start;
    logic             comp_busy;
    logic [31:0]      comp_idx;
    logic             comp_done;
    logic             comp_stall;
    logic [31:0]      comp_returndata;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [31:0]      res_idx;

    logic             job_done;
    logic [31:0]      job_sum;
    logic             active;

    modport master (
        input  cmd_valid, cmd_base, cmd_count,
        input  comp_busy, comp_done, comp_returndata,
        input  res_ready,
        output cmd_ready,
        output comp_start, comp_idx, comp_stall,
        output res_valid, res_data, res_idx,
        output job_done, job_sum, active
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_count,
        output comp_busy, comp_done, comp_returndata,
        output res_ready,
        input  cmd_ready,
        input  comp_start, comp_idx, comp_stall,
        input  res_valid, res_data, res_idx,
        input  job_done, job_sum, active
    );

endinterface

// File: rtl/mibench_result_fifo.sv
// Show-ahead FIFO of (index, data) results: head is visible the cycle after
// the push, and push with pop is accepted even when full.
module mibench_result_fifo
    import mibench_drv_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic    clock,
    input  logic    resetn,
    input  logic    push,
    input  result_t push_data,
    input  logic    pop,
    output result_t head,
    output logic    full,
    output logic    empty,
    output logic [AW:0] count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    result_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        do_push  = push & ((count_q != FULL_CNT) | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mibench_call_driver.sv
// Issues one component call per index of a host job, collects the in-order
// returns into a result FIFO and reports a per-job sum and completion pulse.
module mibench_call_driver
    import mibench_drv_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clock,
    input  logic                  resetn,
    mibench_call_driver_if.master bus
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    state_e           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [CNT_W-1:0] job_cnt_q, job_cnt_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] received_q, received_d;
    logic [AW:0]      outst_q, outst_d;
    logic [31:0]      sum_q, sum_d;
    logic [31:0]      comp_idx_q, comp_idx_d;
    logic [31:0]      job_sum_q, job_sum_d;
    logic             comp_start_q, comp_start_d;
    logic             job_done_q, job_done_d;

    logic        fifo_full, fifo_empty;
    logic [AW:0] fifo_cnt, fifo_cnt_next, credit_next;
    logic        call_acc, res_acc, res_counted, pop;
    result_t     push_entry, head;

    assign call_acc    = comp_start_q & ~bus.comp_busy;
    assign res_acc     = bus.comp_done & ~fifo_full;
    assign res_counted = res_acc & (state_q != IDLE);
    assign pop         = ~fifo_empty & bus.res_ready;
    assign push_entry  = '{idx: base_q + 32'(received_q), data: bus.comp_returndata};

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        job_cnt_d  = job_cnt_q;
        issued_d   = issued_q + CNT_W'(call_acc);
        received_d = received_q + CNT_W'(res_counted);
        outst_d    = outst_q + (AW+1)'(call_acc) - (AW+1)'(res_counted);
        sum_d      = res_counted ? sum_q + bus.comp_returndata : sum_q;
        comp_idx_d = call_acc ? comp_idx_q + 32'd1 : comp_idx_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    base_d     = bus.cmd_base;
                    job_cnt_d  = bus.cmd_count;
                    issued_d   = '0;
                    received_d = '0;
                    sum_d      = '0;
                    comp_idx_d = bus.cmd_base;
                    state_d    = (bus.cmd_count != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                if (call_acc && issued_d == job_cnt_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (received_q == job_cnt_q && outst_q == '0) begin
                    state_d = FINISH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Credit is evaluated on next-cycle occupancy so a registered start
        // never over-commits FIFO space, even across the issue cycle itself.
        fifo_cnt_next = fifo_cnt + (AW+1)'(res_acc) - (AW+1)'(pop);
        credit_next   = DEPTH_C - fifo_cnt_next - outst_d;
        comp_start_d  = (comp_start_q & bus.comp_busy)
                      | ((state_d == ISSUE) & (issued_d < job_cnt_d) & (credit_next != '0));

        job_done_d = (state_d == FINISH);
        job_sum_d  = (state_d == FINISH) ? sum_d : job_sum_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            base_q       <= '0;
            job_cnt_q    <= '0;
            issued_q     <= '0;
            received_q   <= '0;
            outst_q      <= '0;
            sum_q        <= '0;
            comp_idx_q   <= '0;
            job_sum_q    <= '0;
            comp_start_q <= 1'b0;
            job_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            job_cnt_q    <= job_cnt_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            outst_q      <= outst_d;
            sum_q        <= sum_d;
            comp_idx_q   <= comp_idx_d;
            job_sum_q    <= job_sum_d;
            comp_start_q <= comp_start_d;
            job_done_q   <= job_done_d;
        end
    end

    mibench_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (res_acc),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.comp_start = comp_start_q;
    assign bus.comp_idx   = comp_idx_q;
    assign bus.comp_stall = fifo_full;
    assign bus.res_valid  = ~fifo_empty;
    assign bus.res_data   = head.data;
    assign bus.res_idx    = head.idx;
    assign bus.job_done   = job_done_q;
    assign bus.job_sum    = job_sum_q;
    assign bus.active     = (state_q != IDLE);

endmodule
